// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: digit count, active-low anode codes,
// scan FSM state type and digit-rotation helpers used by scanner and decoder.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = 4'b1111;
    localparam logic [NUM_DIGITS-1:0] ANODE_DIG0 = 4'b1110;
    localparam logic [NUM_DIGITS-1:0] ANODE_DIG1 = 4'b1101;
    localparam logic [NUM_DIGITS-1:0] ANODE_DIG2 = 4'b1011;
    localparam logic [NUM_DIGITS-1:0] ANODE_DIG3 = 4'b0111;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    // Nearest enabled digit above cur, wrapping 3->0; cur itself if
    // no other digit is enabled (including the empty-mask case).
    function automatic logic [1:0] next_digit(
        input logic [1:0]            cur,
        input logic [NUM_DIGITS-1:0] mask
    );
        logic [1:0] idx;
        logic [1:0] res;
        res = cur;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int k = 3; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (mask[idx]) res = idx;
        end
        return res;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [1:0] sel);
        logic [NUM_DIGITS-1:0] a;
        unique case (sel)
            2'd0: a = ANODE_DIG0;
            2'd1: a = ANODE_DIG1;
            2'd2: a = ANODE_DIG2;
            2'd3: a = ANODE_DIG3;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/anode_scanner_if.sv
// Anode bus between the scanner (master) and the display decoder (slave).
// Signals: enable, digit_en in; anode, digit_sel, digit_step, frame_done out.
interface anode_scanner_if;
    import seg_pkg::*;

    logic                  enable;
    logic [NUM_DIGITS-1:0] digit_en;
    logic [NUM_DIGITS-1:0] anode;
    logic [1:0]            digit_sel;
    logic                  digit_step;
    logic                  frame_done;

    modport master (
        input  enable,
        input  digit_en,
        output anode,
        output digit_sel,
        output digit_step,
        output frame_done
    );

    modport slave (
        output enable,
        output digit_en,
        input  anode,
        input  digit_sel,
        input  digit_step,
        input  frame_done
    );

endinterface

// File: rtl/scan_timer.sv
// Clearable up-counter shared by the scanner's timed states.
// Ports: clk, rst (sync, high), i_clear, i_last (terminal value), o_tc.
module scan_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic [W-1:0] i_last,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) r_cnt <= '0;
        else                r_cnt <= r_cnt + W'(1);
    end

    assign o_tc = (r_cnt == i_last);

endmodule

// File: rtl/anode_scanner.sv
// Time-multiplexed active-low anode driver for a 4-digit display.
// Ports: clk, rst (sync, high), io_bus (anode_scanner_if.master).
// ANODE_SCANNER_BLANK_EN: insert an all-off gap between digits.
module anode_scanner #(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    anode_scanner_if.master  io_bus
);
    import seg_pkg::*;

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ?
                             DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

`ifdef ANODE_SCANNER_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam scan_state_t      GAP_STATE  = BLANK;
`else
    localparam scan_state_t      GAP_STATE  = ON;
`endif

    scan_state_t           r_state;
    logic [1:0]            r_sel;
    logic [NUM_DIGITS-1:0] r_anode;
    logic                  r_step;
    logic                  r_frame;

    scan_state_t           w_state_nx;
    logic [1:0]            w_sel_nx;
    logic [1:0]            w_adv;
    logic [NUM_DIGITS-1:0] w_anode_nx;
    logic                  w_step_nx;
    logic                  w_frame_nx;
    logic                  w_clr;
    logic                  w_tc;
    logic [CNT_W-1:0]      w_last;

`ifdef ANODE_SCANNER_BLANK_EN
    assign w_last = (r_state == ON) ? DWELL_LAST : BLANK_LAST;
`else
    assign w_last = DWELL_LAST;
`endif

    scan_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clr),
        .i_last  (w_last),
        .o_tc    (w_tc)
    );

    assign w_adv = next_digit(r_sel, io_bus.digit_en);

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_step_nx  = 1'b0;
        w_frame_nx = 1'b0;
        w_clr      = 1'b0;
        if (!io_bus.enable) begin
            w_state_nx = OFF;
            w_clr      = 1'b1;
        end else begin
            unique case (r_state)
                OFF: begin
                    w_state_nx = GAP_STATE;
                    w_clr      = 1'b1;
                end
`ifdef ANODE_SCANNER_BLANK_EN
                BLANK: begin
                    if (w_tc) begin
                        w_state_nx = ON;
                        w_clr      = 1'b1;
                    end
                end
`endif
                ON: begin
                    if (w_tc) begin
                        w_state_nx = GAP_STATE;
                        w_sel_nx   = w_adv;
                        w_step_nx  = 1'b1;
                        // Equal index counts as a wrap (empty or single mask).
                        w_frame_nx = (w_adv <= r_sel);
                        w_clr      = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = OFF;
                    w_clr      = 1'b1;
                end
            endcase
        end
        // Anode follows the mask live so mask edits apply on the next edge.
        if (w_state_nx == ON && io_bus.digit_en[w_sel_nx])
            w_anode_nx = anode_for(w_sel_nx);
        else
            w_anode_nx = ANODE_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OFF;
            r_sel   <= 2'd0;
            r_anode <= ANODE_OFF;
            r_step  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_anode <= w_anode_nx;
            r_step  <= w_step_nx;
            r_frame <= w_frame_nx;
        end
    end

    assign io_bus.anode      = r_anode;
    assign io_bus.digit_sel  = r_sel;
    assign io_bus.digit_step = r_step;
    assign io_bus.frame_done = r_frame;

endmodule

// File: tb/tb_anode_scanner.sv
// Scoreboard bench for anode_scanner: per-cycle expected outputs from a
// behavioural display model are queued and compared on the falling edge.
module tb_anode_scanner;

    localparam int DW = 4;
    localparam int BL = 2;
`ifdef ANODE_SCANNER_BLANK_EN
    localparam bit HAS_BLANK = 1'b1;
`else
    localparam bit HAS_BLANK = 1'b0;
`endif
    localparam int DIGIT_PERIOD = HAS_BLANK ? (DW + BL) : DW;
    localparam int FRAME_LEN    = 4 * DIGIT_PERIOD;

    localparam int DARK = 0;
    localparam int GAP  = 1;
    localparam int LIT  = 2;

    typedef struct packed {
        logic [3:0] anode;
        logic [1:0] sel;
        logic       step;
        logic       frame;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    anode_scanner_if bus ();

    anode_scanner #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   meas     = 1'b0;
    int   prev_frame = -1;

    // Model: which phase the display is in, edges left in it, lit digit.
    int   m_phase = DARK;
    int   m_left  = 0;
    int   m_sel   = 0;

    function automatic int pick_next(input int cur, input logic [3:0] mask);
        int nxt;
        nxt = -1;
        for (int i = 0; i < 4; i++)
            if (mask[i] && i > cur && nxt < 0) nxt = i;
        for (int i = 0; i < 4; i++)
            if (mask[i] && nxt < 0) nxt = i;
        if (nxt < 0) nxt = cur;
        return nxt;
    endfunction

    always @(posedge clk) begin
        obs_t       e;
        logic [3:0] one;
        int         nxt;
        e.step  = 1'b0;
        e.frame = 1'b0;
        if (rst) begin
            m_phase = DARK;
            m_sel   = 0;
        end else if (!bus.enable) begin
            m_phase = DARK;
        end else if (m_phase == DARK) begin
            m_phase = HAS_BLANK ? GAP : LIT;
            m_left  = HAS_BLANK ? BL - 1 : DW - 1;
        end else if (m_left > 0) begin
            m_left--;
        end else if (m_phase == GAP) begin
            m_phase = LIT;
            m_left  = DW - 1;
        end else begin
            nxt     = pick_next(m_sel, bus.digit_en);
            e.step  = 1'b1;
            e.frame = (nxt <= m_sel);
            m_sel   = nxt;
            m_phase = HAS_BLANK ? GAP : LIT;
            m_left  = HAS_BLANK ? BL - 1 : DW - 1;
        end
        one     = 4'b0001;
        e.sel   = 2'(m_sel);
        e.anode = (m_phase == LIT && bus.digit_en[m_sel]) ?
                  ~(one << m_sel) : 4'b1111;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        obs_t a;
        obs_t e;
        cyc++;
        a = {bus.anode, bus.digit_sel, bus.digit_step, bus.frame_done};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty cyc=%0d actual=%b required an expected entry",
                     cyc, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d actual anode=%b sel=%0d step=%b frame=%b required anode=%b sel=%0d step=%b frame=%b",
                         cyc, a.anode, a.sel, a.step, a.frame,
                         e.anode, e.sel, e.step, e.frame);
            end
        end
        if (!meas) begin
            prev_frame = -1;
        end else if (bus.frame_done === 1'b1) begin
            if (prev_frame >= 0) begin
                n_checks++;
                if (cyc - prev_frame != FRAME_LEN) begin
                    n_fail++;
                    $display("FAIL frame_len actual=%0d required=%0d",
                             cyc - prev_frame, FRAME_LEN);
                end
            end
            prev_frame = cyc;
        end
    end

    task automatic wait_lit(input int d);
        int k;
        k = 0;
        while (!(m_phase == LIT && m_sel == d) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL wait_lit digit=%0d not lit after %0d cycles, required within 100",
                     d, k);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.enable   = 1'b1;
        bus.digit_en = 4'b1111;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        meas = 1'b1;
        repeat (3 * FRAME_LEN + 4) @(negedge clk);
        meas = 1'b0;

        bus.digit_en = 4'b0101;
        repeat (40) @(negedge clk);

        bus.digit_en = 4'b0000;
        repeat (30) @(negedge clk);

        bus.digit_en = 4'b1111;
        wait_lit(2);
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        bus.enable = 1'b1;
        repeat (20) @(negedge clk);

        wait_lit(1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) bus.digit_en = 4'($urandom);
            bus.enable = ($urandom_range(0, 19) != 0);
            rst        = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst        = 1'b0;
        bus.enable = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
